// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU AXI read DMA: FSM states, AXI encodings
// and parameter defaults.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_SRAM_AW  = 12;
  localparam int DEF_NUM_CH   = 3;
  localparam int DEF_MAX_OUTS = 4;

  // AXI AxSIZE encoding for a full-width beat of data_w bits.
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/lsu_ar_gen.sv
// Row address generator: walks cmd_num rows from the DRAM base by cmd_str bytes and
// presents one INCR burst per row on the AXI AR channel.
module lsu_ar_gen
  import lsu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              active,
  input  logic              room,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [ADDR_W-1:0] cmd_dram_addr,
  input  logic [7:0]        cmd_num,
  input  logic [2:0]        cmd_len,
  input  logic [15:0]       cmd_str,
  output logic [7:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvld,
  input  logic              arrdy,
  output logic              ar_hs,
  output logic              last_hs
);

  logic [CH_W-1:0]   ch_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        num_reg;
  logic [7:0]        rows_reg;
  logic [2:0]        len_reg;
  logic [15:0]       str_reg;

  assign arvld   = active && (rows_reg < num_reg) && room;
  assign ar_hs   = arvld && arrdy;
  assign last_hs = ar_hs && (rows_reg == num_reg - 8'd1);

  // Payload is forced to zero whenever no request is offered; it only moves on a
  // handshake, so it is stable while arvld waits for arrdy.
  assign arid    = arvld ? {{(8 - CH_W){1'b0}}, ch_reg} : 8'd0;
  assign araddr  = arvld ? addr_reg : '0;
  assign arlen   = arvld ? 8'((9'd1 << len_reg) - 9'd1) : 8'd0;
  assign arsize  = arvld ? axi_size(DATA_W) : 3'd0;
  assign arburst = arvld ? AXI_BURST_INCR : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_reg   <= '0;
      addr_reg <= '0;
      num_reg  <= '0;
      rows_reg <= '0;
      len_reg  <= '0;
      str_reg  <= '0;
    end else if (start) begin
      ch_reg   <= cmd_ch;
      addr_reg <= cmd_dram_addr;
      num_reg  <= cmd_num;
      rows_reg <= '0;
      len_reg  <= cmd_len;
      str_reg  <= cmd_str;
    end else if (ar_hs) begin
      rows_reg <= rows_reg + 8'd1;
      addr_reg <= addr_reg + ADDR_W'(str_reg);
    end
  end

endmodule

// File: rtl/lsu_axi_rd_dma.sv
// LSU read DMA: fetches strided rows from DRAM over AXI and streams every R beat
// into one of NUM_CH SRAMs at consecutive word addresses.
module lsu_axi_rd_dma
  import lsu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SRAM_AW  = DEF_SRAM_AW,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int MAX_OUTS = DEF_MAX_OUTS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_vld,
  output logic                       cmd_rdy,
  input  logic [$clog2(NUM_CH)-1:0]  cmd_ch,
  input  logic [ADDR_W-1:0]          cmd_dram_addr,
  input  logic [SRAM_AW-1:0]         cmd_sram_addr,
  input  logic [7:0]                 cmd_num,
  input  logic [2:0]                 cmd_len,
  input  logic [15:0]                cmd_str,
  output logic [7:0]                 lsu_axi_arid,
  output logic [ADDR_W-1:0]          lsu_axi_araddr,
  output logic [7:0]                 lsu_axi_arlen,
  output logic [2:0]                 lsu_axi_arsize,
  output logic [1:0]                 lsu_axi_arburst,
  output logic                       lsu_axi_arvld,
  input  logic                       axi_lsu_arrdy,
  input  logic [7:0]                 axi_lsu_rid,
  input  logic [DATA_W-1:0]          axi_lsu_rdata,
  input  logic [1:0]                 axi_lsu_rresp,
  input  logic                       axi_lsu_rlast,
  input  logic                       axi_lsu_rvld,
  output logic                       lsu_axi_rrdy,
  output logic [NUM_CH-1:0]          lsu_ram_wr_vld,
  output logic [SRAM_AW-1:0]         lsu_ram_wr_addr,
  output logic [DATA_W-1:0]          lsu_ram_wr_data,
  output logic                       lsu_dma_done,
  output logic                       lsu_dma_err
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int OUTS_W = $clog2(MAX_OUTS + 1);

  state_t              state;
  logic [OUTS_W-1:0]   outs_reg;
  logic [OUTS_W-1:0]   outs_next;
  logic [CH_W-1:0]     ch_reg;
  logic [SRAM_AW-1:0]  ptr_reg;
  logic [NUM_CH-1:0]   wr_vld_reg;
  logic [SRAM_AW-1:0]  wr_addr_reg;
  logic [DATA_W-1:0]   wr_data_reg;
  logic                done_reg;
  logic                err_reg;
  logic [NUM_CH-1:0]   ch_hot;
  logic                accept;
  logic                start;
  logic                room;
  logic                ar_hs;
  logic                last_hs;
  logic                r_hs;
  logic                r_last_hs;
  logic                unused_rid;

  // Beats are routed purely by order and rlast; the returned ID carries no meaning here.
  assign unused_rid = ^axi_lsu_rid;

  assign cmd_rdy      = (state == IDLE);
  assign lsu_axi_rrdy = (state != IDLE);
  assign accept       = cmd_vld && cmd_rdy;
  assign start        = accept && (cmd_num != 8'd0);
  assign room         = outs_reg < OUTS_W'(MAX_OUTS);
  assign r_hs         = axi_lsu_rvld && lsu_axi_rrdy;
  assign r_last_hs    = r_hs && axi_lsu_rlast;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_hot
      assign ch_hot[gi] = (ch_reg == CH_W'(gi));
    end
  endgenerate

  always_comb begin
    outs_next = outs_reg;
    if (ar_hs && !r_last_hs)
      outs_next = outs_reg + OUTS_W'(1);
    else if (!ar_hs && r_last_hs)
      outs_next = outs_reg - OUTS_W'(1);
  end

  lsu_ar_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W)
  ) u_ar_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .active        (state == ISSUE),
    .room          (room),
    .cmd_ch        (cmd_ch),
    .cmd_dram_addr (cmd_dram_addr),
    .cmd_num       (cmd_num),
    .cmd_len       (cmd_len),
    .cmd_str       (cmd_str),
    .arid          (lsu_axi_arid),
    .araddr        (lsu_axi_araddr),
    .arlen         (lsu_axi_arlen),
    .arsize        (lsu_axi_arsize),
    .arburst       (lsu_axi_arburst),
    .arvld         (lsu_axi_arvld),
    .arrdy         (axi_lsu_arrdy),
    .ar_hs         (ar_hs),
    .last_hs       (last_hs)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      outs_reg    <= '0;
      ch_reg      <= '0;
      ptr_reg     <= '0;
      wr_vld_reg  <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      wr_vld_reg <= '0;
      outs_reg   <= outs_next;
      if (r_hs) begin
        wr_vld_reg  <= ch_hot;
        wr_addr_reg <= ptr_reg;
        wr_data_reg <= axi_lsu_rdata;
        ptr_reg     <= ptr_reg + SRAM_AW'(1);
        if (axi_lsu_rresp != AXI_RESP_OKAY)
          err_reg <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            ch_reg  <= cmd_ch;
            ptr_reg <= cmd_sram_addr;
            err_reg <= 1'b0;
            if (cmd_num == 8'd0)
              done_reg <= 1'b1;
            else
              state <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_hs)
            state <= DRAIN;
        end
        DRAIN: begin
          // Done lines up with the SRAM write of the final beat.
          if (outs_next == '0) begin
            state    <= IDLE;
            done_reg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu_ram_wr_vld  = wr_vld_reg;
  assign lsu_ram_wr_addr = wr_addr_reg;
  assign lsu_ram_wr_data = wr_data_reg;
  assign lsu_dma_done    = done_reg;
  assign lsu_dma_err     = err_reg;

endmodule

// File: tb/tb_lsu_axi_rd_dma.sv
// Bench for lsu_axi_rd_dma: AXI read slave, per-cycle transfer model and directed scenarios.
module tb_lsu_axi_rd_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [1:0]  cmd_ch = '0;
  logic [31:0] cmd_dram_addr = '0;
  logic [11:0] cmd_sram_addr = '0;
  logic [7:0]  cmd_num = '0;
  logic [2:0]  cmd_len = '0;
  logic [15:0] cmd_str = '0;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvld;
  logic        arrdy = 1'b1;
  logic [7:0]  rid = 8'h5A;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvld = 1'b0;
  logic        rrdy;
  logic [2:0]  wr_vld;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic        done;
  logic        err;

  lsu_axi_rd_dma dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_ch(cmd_ch), .cmd_dram_addr(cmd_dram_addr),
    .cmd_sram_addr(cmd_sram_addr), .cmd_num(cmd_num), .cmd_len(cmd_len), .cmd_str(cmd_str),
    .lsu_axi_arid(arid), .lsu_axi_araddr(araddr), .lsu_axi_arlen(arlen), .lsu_axi_arsize(arsize),
    .lsu_axi_arburst(arburst), .lsu_axi_arvld(arvld), .axi_lsu_arrdy(arrdy),
    .axi_lsu_rid(rid), .axi_lsu_rdata(rdata), .axi_lsu_rresp(rresp), .axi_lsu_rlast(rlast),
    .axi_lsu_rvld(rvld), .lsu_axi_rrdy(rrdy),
    .lsu_ram_wr_vld(wr_vld), .lsu_ram_wr_addr(wr_addr), .lsu_ram_wr_data(wr_data),
    .lsu_dma_done(done), .lsu_dma_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer model: what the DMA must be doing, in terms of rows/beats completed.
  bit          m_active = 0;
  int          m_ch = 0;
  logic [31:0] m_addr = '0;
  int          m_sram = 0;
  int          m_num = 0;
  int          m_len = 0;
  int          m_str = 0;
  int          m_ar_cnt = 0;
  int          m_rl_cnt = 0;
  int          m_beat = 0;
  bit          m_err = 0;
  logic [2:0]  s_wr_vld = '0;
  logic [11:0] s_wr_addr = '0;
  logic [63:0] s_wr_data = '0;
  bit          s_done = 0;
  bit          rst_prev = 1;
  bit          r_fire = 0;
  int          done_cnt = 0;

  // Slave and log state.
  int          pend[$];
  logic [31:0] ar_log[$];
  logic [7:0]  ar_len_log[$];
  logic [11:0] wr_log_addr[$];
  logic [2:0]  wr_log_vld[$];
  bit          r_hold = 0;
  bit          arrdy_alt = 0;
  bit          err_inj = 0;
  int          s_beat = 0;
  int          g_beat = 0;

  always @(negedge clk) begin
    bit full;
    bit busy;
    bit exp_arvld;
    full = rst_n || !rst_prev;
    chk("wr_vld", wr_vld, s_wr_vld);
    if (s_wr_vld != 0) begin
      chk("wr_addr", wr_addr, s_wr_addr);
      chk("wr_data", wr_data, s_wr_data);
    end
    if (wr_vld != 0) begin
      wr_log_addr.push_back(wr_addr);
      wr_log_vld.push_back(wr_vld);
    end
    chk("done", done, s_done);
    if (done) done_cnt++;
    if (full) begin
      busy = m_active && (m_rl_cnt < m_num);
      exp_arvld = m_active && (m_ar_cnt < m_num) && ((m_ar_cnt - m_rl_cnt) < 4);
      chk("err", err, m_err);
      chk("cmd_rdy", cmd_rdy, !busy);
      chk("rrdy", rrdy, busy);
      chk("arvld", arvld, exp_arvld);
      if (arvld && exp_arvld) begin
        chk("araddr", araddr, 32'(m_addr + 32'(m_ar_cnt * m_str)));
        chk("arlen", arlen, 8'((1 << m_len) - 1));
        chk("arid", arid, 8'(m_ch));
        chk("arsize", arsize, 3'd3);
        chk("arburst", arburst, 2'b01);
      end
    end
    s_wr_vld = '0;
    s_done = 0;
    if (!rst_n) begin
      m_active = 0; m_err = 0; m_ar_cnt = 0; m_rl_cnt = 0; m_beat = 0; m_num = 0;
      r_fire = 0;
    end else if (cmd_vld && cmd_rdy) begin
      m_ch = int'(cmd_ch); m_addr = cmd_dram_addr; m_sram = int'(cmd_sram_addr);
      m_num = int'(cmd_num); m_len = int'(cmd_len); m_str = int'(cmd_str);
      m_ar_cnt = 0; m_rl_cnt = 0; m_beat = 0; m_err = 0;
      m_active = (cmd_num != 0);
      if (cmd_num == 0) s_done = 1;
    end else begin
      if (arvld && arrdy) begin
        ar_log.push_back(araddr);
        ar_len_log.push_back(arlen);
        pend.push_back((1 << m_len) - 1);
        m_ar_cnt++;
      end
      if (rvld && rrdy) begin
        s_wr_vld = 3'(1 << m_ch);
        s_wr_addr = 12'(m_sram + m_beat);
        s_wr_data = rdata;
        m_beat++;
        r_fire = 1;
        if (rresp != 0) m_err = 1;
        if (rlast) begin
          m_rl_cnt++;
          if (m_rl_cnt == m_num) s_done = 1;
        end
      end
    end
    rst_prev = rst_n;
  end

  // AXI read slave: serves bursts in AR order, one beat per cycle unless held.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend.delete();
      s_beat = 0;
      r_fire = 0;
      rvld = 0;
      rlast = 0;
    end else begin
      if (r_fire) begin
        r_fire = 0;
        g_beat++;
        if (s_beat == pend[0]) begin
          void'(pend.pop_front());
          s_beat = 0;
        end else begin
          s_beat++;
        end
      end
      rvld = !r_hold && (pend.size() > 0);
      rlast = (pend.size() > 0) && (s_beat == pend[0]);
      rdata = {32'hDA7A_0000 + 32'(g_beat), 32'hC0DE_0000 + 32'(g_beat)};
      rresp = (err_inj && s_beat == 1) ? 2'b10 : 2'b00;
    end
    arrdy = arrdy_alt ? ~arrdy : 1'b1;
  end

  task automatic start_cmd(input logic [1:0] ch, input logic [31:0] addr, input logic [11:0] sram,
                           input logic [7:0] num, input logic [2:0] len, input logic [15:0] str);
    bit ok;
    ok = 0;
    ar_log.delete(); ar_len_log.delete(); wr_log_addr.delete(); wr_log_vld.delete();
    @(posedge clk); #1;
    cmd_vld = 1; cmd_ch = ch; cmd_dram_addr = addr; cmd_sram_addr = sram;
    cmd_num = num; cmd_len = len; cmd_str = str;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_rdy) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_vld = 0;
    if (!ok) chk("accept_timeout", 0, 1);
    $display("cmd ch=%0d addr=%h sram=%h num=%0d len=%0d str=%h accepted=%0d", ch, addr, sram, num, len, str, ok);
  endtask

  task automatic wait_done(input int start_cnt);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (done_cnt > start_cnt) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int dc;
    int wc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvld", arvld, 0);
    chk("rst_rrdy", rrdy, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_arsize", arsize, 0);
    chk("rst_arburst", arburst, 0);
    chk("rst_arid", arid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_wr_vld", wr_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Two 4-beat rows into iram.
    dc = done_cnt;
    start_cmd(2'd0, 32'h1000, 12'h010, 8'd2, 3'd2, 16'h0100);
    wait_done(dc);
    repeat (5) @(posedge clk);
    chk("t1_done_once", done_cnt - dc, 1);
    chk("t1_ar_cnt", ar_log.size(), 2);
    chk("t1_ar0", ar_log[0], 32'h1000);
    chk("t1_ar1", ar_log[1], 32'h1100);
    chk("t1_arlen", ar_len_log[0], 8'd3);
    chk("t1_wr_cnt", wr_log_addr.size(), 8);
    chk("t1_wr_first", wr_log_addr[0], 12'h010);
    chk("t1_wr_last", wr_log_addr[7], 12'h017);
    chk("t1_wr_ch", wr_log_vld[0], 3'b001);
    $display("t1 done: ars=%0d writes=%0d", ar_log.size(), wr_log_addr.size());

    // Outstanding limit with R withheld.
    r_hold = 1;
    dc = done_cnt;
    start_cmd(2'd2, 32'h8000, 12'h100, 8'd8, 3'd0, 16'h0040);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t2_ar_held", ar_log.size(), 4);
    chk("t2_arvld_low", arvld, 0);
    r_hold = 0;
    wait_done(dc);
    repeat (3) @(posedge clk);
    chk("t2_ar_total", ar_log.size(), 8);
    chk("t2_ar7", ar_log[7], 32'h81C0);
    chk("t2_wr_cnt", wr_log_addr.size(), 8);
    $display("t2 done: ars=%0d writes=%0d", ar_log.size(), wr_log_addr.size());

    // SRAM pointer wrap into wram.
    dc = done_cnt;
    start_cmd(2'd1, 32'h2000, 12'hFFE, 8'd1, 3'd2, 16'h0000);
    wait_done(dc);
    repeat (2) @(posedge clk);
    chk("t3_wr_cnt", wr_log_addr.size(), 4);
    chk("t3_wr0", wr_log_addr[0], 12'hFFE);
    chk("t3_wr1", wr_log_addr[1], 12'hFFF);
    chk("t3_wr2", wr_log_addr[2], 12'h000);
    chk("t3_wr3", wr_log_addr[3], 12'h001);
    chk("t3_wr_ch", wr_log_vld[3], 3'b010);
    $display("t3 done: writes=%0d", wr_log_addr.size());

    // Error response on beat 2 of 4.
    err_inj = 1;
    dc = done_cnt;
    start_cmd(2'd0, 32'h3000, 12'h020, 8'd1, 3'd2, 16'h0000);
    wait_done(dc);
    err_inj = 0;
    @(negedge clk);
    chk("t4_err_sticky", err, 1);
    chk("t4_wr_cnt", wr_log_addr.size(), 4);
    $display("t4 done: err=%0d writes=%0d", err, wr_log_addr.size());

    // Zero-row command: clears err, no AR, done the cycle after accept.
    dc = done_cnt;
    start_cmd(2'd1, 32'h4000, 12'h000, 8'd0, 3'd1, 16'h0010);
    @(negedge clk);
    chk("t5_err_clear", err, 0);
    chk("t5_done_pulse", done, 1);
    wait_done(dc);
    repeat (3) @(posedge clk);
    chk("t5_no_ar", ar_log.size(), 0);
    chk("t5_done_once", done_cnt - dc, 1);
    $display("t5 done: ars=%0d", ar_log.size());

    // Stalling arrdy and address wrap.
    arrdy_alt = 1;
    dc = done_cnt;
    start_cmd(2'd2, 32'hFFFF_FF00, 12'h200, 8'd3, 3'd1, 16'hFFFF);
    wait_done(dc);
    arrdy_alt = 0;
    repeat (2) @(posedge clk);
    chk("t6_ar2", ar_log[2], 32'h0001_FEFE);
    chk("t6_wr_cnt", wr_log_addr.size(), 6);
    $display("t6 done: ars=%0d writes=%0d", ar_log.size(), wr_log_addr.size());

    // Reset while draining.
    r_hold = 1;
    dc = done_cnt;
    start_cmd(2'd2, 32'h5000, 12'h300, 8'd2, 3'd3, 16'h0080);
    repeat (6) @(posedge clk);
    r_hold = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    wc = wr_log_addr.size();
    chk("t7_cmd_rdy", cmd_rdy, 1);
    repeat (10) @(posedge clk);
    chk("t7_no_done", done_cnt - dc, 0);
    chk("t7_no_writes", wr_log_addr.size(), wc);
    $display("t7 done: writes before reset=%0d", wc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_axi_rd_dma.md
LSU_AXI_RD_DMA -- requirements
Module: lsu_axi_rd_dma

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning AXI R data and SRAM write width in bits (power of two, 8..512).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning DRAM byte-address width.
REQ-003 SHALL have parameter SRAM_AW, default 12, meaning SRAM word-address width.
REQ-004 SHALL have parameter NUM_CH, default 3, meaning number of target SRAMs (0=iram, 1=wram, 2=oram).
REQ-005 SHALL have parameter MAX_OUTS, default 4, meaning maximum outstanding AR bursts.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset; one clock, and reset is synchronous and active-low.
REQ-007 SHALL have ports: cmd_vld in 1; cmd_rdy out 1; cmd_ch in $clog2(NUM_CH); cmd_dram_addr in ADDR_W; cmd_sram_addr in SRAM_AW; cmd_num in 8 (row count); cmd_len in 3 (beats per row = 2^cmd_len); cmd_str in 16 (row stride, bytes).
REQ-008 SHALL have ports: lsu_axi_arid out 8; lsu_axi_araddr out ADDR_W; lsu_axi_arlen out 8; lsu_axi_arsize out 3; lsu_axi_arburst out 2; lsu_axi_arvld out 1; axi_lsu_arrdy in 1.
REQ-009 SHALL have ports: axi_lsu_rid in 8; axi_lsu_rdata in DATA_W; axi_lsu_rresp in 2; axi_lsu_rlast in 1; axi_lsu_rvld in 1; lsu_axi_rrdy out 1.
REQ-010 SHALL have ports: lsu_ram_wr_vld out NUM_CH (one-hot); lsu_ram_wr_addr out SRAM_AW; lsu_ram_wr_data out DATA_W; lsu_dma_done out 1 (pulse); lsu_dma_err out 1 (sticky).

Function
REQ-011 FSM states SHALL be IDLE, ISSUE, DRAIN; cmd_rdy SHALL be 1 only in IDLE.
REQ-012 On cmd_vld&cmd_rdy, command fields SHALL be latched; cmd_num!=0 -> ISSUE; cmd_num==0 -> stay IDLE, lsu_dma_done pulses next cycle, no AXI traffic.
REQ-013 In ISSUE, arvld SHALL be 1 when rows_issued<cmd_num and outstanding<MAX_OUTS; first arvld in the cycle after command accept.
REQ-014 Row k SHALL use araddr=cmd_dram_addr+k*cmd_str (modulo 2^ADDR_W), arlen=2^cmd_len-1, arsize=log2(DATA_W/8), arburst=2'b01 (INCR), arid=cmd_ch zero-extended.
REQ-015 AR payload SHALL hold stable while arvld=1 and arrdy=0.
REQ-016 After the last AR handshake, FSM SHALL go ISSUE->DRAIN.
REQ-017 lsu_axi_rrdy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-018 Each R handshake SHALL produce, one cycle later, a single-cycle write: wr_vld[cmd_ch]=1, wr_data=rdata, wr_addr=write pointer; pointer starts at cmd_sram_addr, increments by 1 per beat, wraps modulo 2^SRAM_AW.
REQ-019 outstanding SHALL increment on AR handshake and decrement on R handshake with rlast; both in one cycle -> unchanged.
REQ-020 In DRAIN, when outstanding reaches 0, FSM SHALL go to IDLE and pulse lsu_dma_done for one cycle, the cycle after the final rlast handshake (coincident with the last SRAM write).
REQ-021 Any R beat with rresp!=0 SHALL set lsu_dma_err; data SHALL still be written; err SHALL clear on next command accept.
REQ-022 rid SHALL NOT be checked; beat count per burst is trusted to rlast.

Reset
REQ-023 On rst_n=0 at a clk edge: state=IDLE, outstanding=0, rows_issued=0, pointer=0, err=0.
REQ-024 Outputs during/after reset SHALL be: cmd_rdy=1 once rst_n=1, arvld=0, rrdy=0, wr_vld=0, done=0, err=0, AR payload 0.
REQ-025 Reset mid-transfer SHALL abandon it without done pulse or further SRAM writes.

Structure
REQ-026 Package lsu_pkg SHALL hold the FSM state enum, AXI burst/resp constants (INCR, OKAY) and parameter defaults.
REQ-027 Row address generator SHALL be sub-module lsu_ar_gen (row counter, stride accumulator, AR handshake); the rest SHALL stay in lsu_axi_rd_dma.

Verification
REQ-028 cmd_ch=0, addr=0x1000, sram=0x010, num=2, len=2, str=0x100, arrdy/rvld always 1 -> AR 0x1000/0x1100 arlen=3 arsize=3; 8 iram writes at 0x010..0x017; done once.
REQ-029 num=8, len=0, arrdy=1, R withheld -> exactly 4 ARs then arvld=0; releasing R completes remaining 4 ARs; done after 8th rlast.
REQ-030 sram=0xFFE, num=1, len=2, ch=1 -> wram writes at 0xFFE,0xFFF,0x000,0x001.
REQ-031 Beat 2 of 4 has rresp=2'b10 -> all 4 beats written, err=1 after done; err clears on next accept.
REQ-032 num=0 -> no arvld, done pulses cycle after accept; rst_n=0 during DRAIN -> no done, wr_vld stays 0, cmd_rdy=1 after reset.
